// File: rtl/countdown_timer.sv
// countdown_timer: key-driven MM:SS.cc countdown timer for the DE1-SOC board.
// Three raw active-low keys are synchronised and debounced. The user presets
// minutes and seconds, and the count then runs down at 10 ms resolution.
// An alarm is raised when the count reaches zero. All displayed digits are BCD.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN. When it is defined and the
// preset is non-zero, reaching zero reloads the preset and the count keeps running.
module countdown_timer #(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV       = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_set,
  input  logic       key_inc,
  input  logic       key_start_pause,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       led0,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic       alarm
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {READY, SET_MIN, SET_SEC, RUN, PAUSE, DONE} stateT;

  stateT         r_state, w_stateNext;
  logic [23:0]   r_count, w_countNext, r_preset, w_presetNext, w_countDec;
  logic [PW-1:0] r_presc, w_prescNext;
  logic [BW-1:0] r_blinkCnt;
  logic          r_blinkPhase;
  logic [2:0]    w_keyRaw, r_sync1, r_sync2, r_stable, r_pulse;
  logic [DW-1:0] r_debCnt [3];
  logic          w_setPulse, w_startPulse, w_incPulse, w_blankMin, w_blankSec;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic          w_reloadEvt, r_reloadFlag, r_reloadToggle;
`endif

  // Key bit order {start_pause, inc, set}.
  assign w_keyRaw = {key_start_pause, key_inc, key_set};

  // Set wins over start, and start wins over inc. Lower-priority pulses in the same cycle are lost.
  assign w_setPulse   = r_pulse[0];
  assign w_startPulse = r_pulse[2] & ~r_pulse[0];
  assign w_incPulse   = r_pulse[1] & ~r_pulse[0] & ~r_pulse[2];

  function automatic logic [7:0] incMin(input logic [7:0] m);
    if (m[3:0] == 4'd9) return {((m[7:4] == 4'd9) ? 4'd0 : m[7:4] + 4'd1), 4'd0};
    return {m[7:4], m[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] incSec(input logic [7:0] s);
    if (s[3:0] == 4'd9) return {((s[7:4] == 4'd5) ? 4'd0 : s[7:4] + 4'd1), 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // Digit 0 is the centisecond ones digit and digit 5 is the minute tens digit.
  // The seconds tens digit (index 3) borrows back to 5; every other digit borrows back to 9.
  function automatic logic [23:0] decCount(input logic [23:0] c);
    logic [5:0][3:0] d;
    logic            borrow;
    d      = c;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (d[i] != 4'd0) begin
          d[i]   = d[i] - 4'd1;
          borrow = 1'b0;
        end else begin
          d[i] = (i == 3) ? 4'd5 : 4'd9;
        end
      end
    end
    return d;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign w_countDec = decCount(r_count);

  // Synchronise and debounce each key, then emit a 1-cycle pulse when a press is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      r_pulse  <= '0;
      for (int i = 0; i < 3; i++) r_debCnt[i] <= '0;
    end else begin
      r_sync1 <= w_keyRaw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        r_pulse[i] <= 1'b0;
        if (r_sync2[i] == r_stable[i]) begin
          r_debCnt[i] <= '0;
        end else if (r_debCnt[i] == DEB_LAST) begin
          r_debCnt[i] <= '0;
          r_stable[i] <= r_sync2[i];
          r_pulse[i]  <= ~r_sync2[i];
        end else begin
          r_debCnt[i] <= r_debCnt[i] + 1'b1;
        end
      end
    end
  end

  // Register the FSM state, the count, the preset and the prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= READY;
      r_count  <= '0;
      r_preset <= '0;
      r_presc  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_count  <= w_countNext;
      r_preset <= w_presetNext;
      r_presc  <= w_prescNext;
    end
  end

  // Next-state logic and count update. A tick's decrement is applied before a pause request takes effect.
  always_comb begin
    w_stateNext  = r_state;
    w_countNext  = r_count;
    w_presetNext = r_preset;
    w_prescNext  = r_presc;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    w_reloadEvt  = 1'b0;
`endif
    case (r_state)
      READY: begin
        w_prescNext = '0;
        if (w_setPulse) w_stateNext = SET_MIN;
        else if (w_startPulse && (r_count != '0)) w_stateNext = RUN;
      end
      SET_MIN: begin
        w_prescNext = '0;
        if (w_setPulse) w_stateNext = SET_SEC;
        else if (w_incPulse) w_countNext[23:16] = incMin(r_count[23:16]);
      end
      SET_SEC: begin
        w_prescNext = '0;
        if (w_setPulse) begin
          w_stateNext  = READY;
          w_countNext  = {r_count[23:8], 8'h00};
          w_presetNext = {r_count[23:8], 8'h00};
        end else if (w_incPulse) begin
          w_countNext[15:8] = incSec(r_count[15:8]);
        end
      end
      RUN: begin
        if (r_presc == TICK_LAST) begin
          w_prescNext = '0;
          w_countNext = w_countDec;
          if (w_countDec == '0) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (r_preset != '0) begin
              w_countNext = r_preset;
              w_reloadEvt = 1'b1;
            end else begin
              w_stateNext = DONE;
            end
`else
            w_stateNext = DONE;
`endif
          end
        end else begin
          w_prescNext = r_presc + 1'b1;
        end
        if (w_startPulse && (w_stateNext == RUN)) w_stateNext = PAUSE;
      end
      PAUSE: begin
        if (w_startPulse) begin
          w_stateNext = RUN;
        end else if (w_setPulse) begin
          w_stateNext = READY;
          w_countNext = r_preset;
          w_prescNext = '0;
        end
      end
      DONE: begin
        w_prescNext = '0;
        if (w_startPulse || w_setPulse) begin
          w_stateNext = READY;
          w_countNext = r_preset;
        end
      end
      default: w_stateNext = READY;
    endcase
  end

  // The blink phase advances only while a field is being edited; otherwise it is cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if ((r_state == SET_MIN) || (r_state == SET_SEC)) begin
      if (r_blinkCnt == BLINK_LAST) begin
        r_blinkCnt   <= '0;
        r_blinkPhase <= ~r_blinkPhase;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
    end else begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Record each reload: one flag for the 1-clk alarm pulse, and a toggle bit that drives led3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reloadFlag   <= 1'b0;
      r_reloadToggle <= 1'b0;
    end else begin
      r_reloadFlag <= w_reloadEvt;
      if (w_reloadEvt) r_reloadToggle <= ~r_reloadToggle;
      else if ((r_state != RUN) && (r_state != PAUSE)) r_reloadToggle <= 1'b0;
    end
  end
`endif

  assign w_blankMin = (r_state == SET_MIN) && !r_blinkPhase;
  assign w_blankSec = (r_state == SET_SEC) && !r_blinkPhase;

  // Registered display and LED outputs, which lag the state and count by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex0  <= 7'h40;
      hex1  <= 7'h40;
      hex2  <= 7'h40;
      hex3  <= 7'h40;
      hex4  <= 7'h40;
      hex5  <= 7'h40;
      led0  <= 1'b0;
      led1  <= 1'b0;
      led2  <= 1'b0;
      led3  <= 1'b0;
      alarm <= 1'b0;
    end else begin
      hex5  <= w_blankMin ? 7'h7F : seg7(r_count[23:20]);
      hex4  <= w_blankMin ? 7'h7F : seg7(r_count[19:16]);
      hex3  <= w_blankSec ? 7'h7F : seg7(r_count[15:12]);
      hex2  <= w_blankSec ? 7'h7F : seg7(r_count[11:8]);
      hex1  <= seg7(r_count[7:4]);
      hex0  <= seg7(r_count[3:0]);
      led0  <= (r_state == SET_MIN) || (r_state == SET_SEC);
      led1  <= (r_state == RUN);
      led2  <= (r_state == PAUSE);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      led3  <= (r_state == DONE) || r_reloadToggle;
      alarm <= (r_state == DONE) || r_reloadFlag;
`else
      led3  <= (r_state == DONE);
      alarm <= (r_state == DONE);
`endif
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed test of countdown_timer with small dividers
// (TICK_DIV=4, DEBOUNCE_CYCLES=3, BLINK_DIV=8).
`timescale 1ns/1ps
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_set, key_inc, key_start_pause;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       led0, led1, led2, led3, alarm;
  logic [41:0] hexNow;
  logic [4:0]  ledsNow;
  logic [41:0] e;
  int errors = 0;
  int checks = 0;

  localparam logic [2:0] K_SET   = 3'b001;
  localparam logic [2:0] K_INC   = 3'b010;
  localparam logic [2:0] K_START = 3'b100;

  countdown_timer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3), .BLINK_DIV(8)) dut (
    .clk(clk), .reset(reset), .key_set(key_set), .key_inc(key_inc),
    .key_start_pause(key_start_pause),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .led0(led0), .led1(led1), .led2(led2), .led3(led3), .alarm(alarm)
  );

  always #5 clk = ~clk;

  assign hexNow  = {hex5, hex4, hex3, hex2, hex1, hex0};
  assign ledsNow = {led3, led2, led1, led0, alarm};

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] expHex(input int mm, input int ss, input int cc);
    return {segOf(mm / 10), segOf(mm % 10), segOf(ss / 10), segOf(ss % 10),
            segOf(cc / 10), segOf(cc % 10)};
  endfunction

  // Count one comparison and report it when the observed value differs from the expected value.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Press the masked keys. The task returns 1 ns after the edge on which the FSM acts.
  task automatic applyStimulus(input logic [2:0] mask);
    repeat (8) @(negedge clk);
    if (mask[0]) key_set = 1'b0;
    if (mask[1]) key_inc = 1'b0;
    if (mask[2]) key_start_pause = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    key_set = 1'b1;
    key_inc = 1'b1;
    key_start_pause = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    key_set = 1'b1;
    key_inc = 1'b1;
    key_start_pause = 1'b1;
    waitCycles(3);
    checkOutput("reset_leds", ledsNow, 5'b00000);
    checkOutput("reset_hex", hexNow, expHex(0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // Hold start low for only two cycles: the debouncer must reject it.
    @(negedge clk);
    key_start_pause = 1'b0;
    repeat (2) @(posedge clk);
    #1 key_start_pause = 1'b1;
    waitCycles(12);
    checkOutput("glitch_leds", ledsNow, 5'b00000);
    applyStimulus(K_START);
    waitCycles(1);
    checkOutput("start_at_zero_leds", ledsNow, 5'b00000);
    checkOutput("start_at_zero_hex", hexNow, expHex(0, 0, 0));

    // Preset 01:05.00, then run.
    applyStimulus(K_SET);
    waitCycles(1);
    checkOutput("set_min_leds", ledsNow, 5'b00010);
    applyStimulus(K_INC);
    applyStimulus(K_SET);
    waitCycles(1);
    e = expHex(1, 0, 0);
    checkOutput("set_sec_minutes", hexNow[41:28], e[41:28]);
    repeat (5) applyStimulus(K_INC);
    applyStimulus(K_SET);
    waitCycles(1);
    checkOutput("preset_hex", hexNow, expHex(1, 5, 0));
    checkOutput("preset_leds", ledsNow, 5'b00000);
    applyStimulus(K_START);
    waitCycles(1);
    checkOutput("run_leds", ledsNow, 5'b00100);
    waitCycles(3);
    checkOutput("run_before_tick", hexNow, expHex(1, 5, 0));
    waitCycles(1);
    checkOutput("run_first_tick", hexNow, expHex(1, 4, 99));

    // Pause 18 cycles after start: four ticks have elapsed and the prescaler holds 2.
    applyStimulus(K_START);
    waitCycles(1);
    checkOutput("pause_leds", ledsNow, 5'b01000);
    checkOutput("pause_hex", hexNow, expHex(1, 4, 96));
    waitCycles(100);
    checkOutput("pause_hold_hex", hexNow, expHex(1, 4, 96));
    checkOutput("pause_hold_leds", ledsNow, 5'b01000);
    applyStimulus(K_START);
    waitCycles(2);
    checkOutput("resume_before_tick", hexNow, expHex(1, 4, 96));
    checkOutput("resume_leds", ledsNow, 5'b00100);
    waitCycles(1);
    checkOutput("resume_tick", hexNow, expHex(1, 4, 95));

    // Asynchronous reset while running.
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("reset_async_leds", ledsNow, 5'b00000);
    waitCycles(1);
    checkOutput("reset_async_hex", hexNow, expHex(0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // Borrow across the minutes: 01:00.00 becomes 00:59.99.
    applyStimulus(K_SET);
    applyStimulus(K_INC);
    applyStimulus(K_SET);
    applyStimulus(K_SET);
    applyStimulus(K_START);
    waitCycles(4);
    checkOutput("borrow_before", hexNow, expHex(1, 0, 0));
    waitCycles(1);
    checkOutput("borrow_minutes", hexNow, expHex(0, 59, 99));

    // Preset 00:01.00 and run down to zero (100 ticks, 400 cycles).
    doReset();
    applyStimulus(K_SET);
    applyStimulus(K_SET);
    applyStimulus(K_INC);
    applyStimulus(K_SET);
    applyStimulus(K_START);
    waitCycles(393);
    checkOutput("near_zero_hex", hexNow, expHex(0, 0, 2));
    waitCycles(7);
    checkOutput("last_cs_hex", hexNow, expHex(0, 0, 1));
    checkOutput("last_cs_leds", ledsNow, 5'b00100);
    waitCycles(1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    checkOutput("reload_leds", ledsNow, 5'b10101);
    checkOutput("reload_hex", hexNow, expHex(0, 1, 0));
    waitCycles(1);
    checkOutput("reload_pulse_end", ledsNow, 5'b10100);
    applyStimulus(K_START);
    applyStimulus(K_SET);
    waitCycles(1);
`else
    checkOutput("done_leds", ledsNow, 5'b10001);
    checkOutput("done_hex", hexNow, expHex(0, 0, 0));
    waitCycles(10);
    checkOutput("done_hold_hex", hexNow, expHex(0, 0, 0));
    applyStimulus(K_START);
    waitCycles(1);
`endif
    checkOutput("ack_leds", ledsNow, 5'b00000);
    checkOutput("ack_hex", hexNow, expHex(0, 1, 0));

    // Set and start together in READY: set wins. Then check the minutes blink.
    applyStimulus(K_SET | K_START);
    waitCycles(1);
    checkOutput("prio_leds", ledsNow, 5'b00010);
    checkOutput("blink_off_a", hexNow[41:28], 14'h3FFF);
    e = expHex(0, 1, 0);
    checkOutput("blink_sec_visible", hexNow[27:14], e[27:14]);
    waitCycles(7);
    checkOutput("blink_off_b", hexNow[41:28], 14'h3FFF);
    waitCycles(1);
    checkOutput("blink_on_a", hexNow[41:28], e[41:28]);
    waitCycles(7);
    checkOutput("blink_on_b", hexNow[41:28], e[41:28]);
    waitCycles(1);
    checkOutput("blink_off_c", hexNow[41:28], 14'h3FFF);
    applyStimulus(K_START);
    waitCycles(1);
    checkOutput("start_in_set_ignored", ledsNow, 5'b00010);

    // Minutes up to 99, seconds wrapping 59 -> 00, then minutes 99 -> 00.
    repeat (99) applyStimulus(K_INC);
    applyStimulus(K_SET);
    waitCycles(1);
    e = expHex(99, 0, 0);
    checkOutput("minutes_99", hexNow[41:28], e[41:28]);
    repeat (59) applyStimulus(K_INC);
    applyStimulus(K_SET);
    waitCycles(1);
    checkOutput("sec_wrap_hex", hexNow, expHex(99, 0, 0));
    applyStimulus(K_SET);
    applyStimulus(K_INC);
    applyStimulus(K_SET);
    waitCycles(1);
    e = expHex(0, 0, 0);
    checkOutput("min_wrap", hexNow[41:28], e[41:28]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
